// File: rtl/eth_tx_arbiter_if.sv
// Requester-side byte streams for eth_tx_arbiter.
// Two independent sources, each with a valid/data/last/ready handshake.
// A byte moves when valid and ready are both high at a clock edge.
//   master : the frame source (drives valid/data/last, receives ready)
//   slave  : the arbiter (receives valid/data/last, drives ready)
interface eth_tx_arbiter_if;
  logic       in_req0_valid;
  logic [7:0] in_req0_data;
  logic       in_req0_last;
  logic       out_req0_ready;

  logic       in_req1_valid;
  logic [7:0] in_req1_data;
  logic       in_req1_last;
  logic       out_req1_ready;

  modport master (
    output in_req0_valid, in_req0_data, in_req0_last,
    output in_req1_valid, in_req1_data, in_req1_last,
    input  out_req0_ready, out_req1_ready
  );

  modport slave (
    input  in_req0_valid, in_req0_data, in_req0_last,
    input  in_req1_valid, in_req1_data, in_req1_last,
    output out_req0_ready, out_req1_ready
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// GMII transmit arbiter: shares one byte-wide PHY transmit path between two
// frame sources. Round-robin arbitration, preamble/SFD insertion,
// inter-frame gap, and abort on underrun or oversize frames.
// Ports:
//   clk, rst_n        byte clock, synchronous active-low reset
//   req               two requester byte streams (slave side)
//   out_txen/out_txd  to PHY in_txen/in_txd
//   out_grant         one-hot owner of the current frame, 0 when unowned
//   out_busy          high from grant through the end of the IFG
//   out_abort         one-cycle pulse when a frame is aborted
//   out_frame_count   successfully sent frames, wrapping
module eth_tx_arbiter #(
  parameter int unsigned IFG_BYTES      = 12,
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MAX_FRAME      = 1518
) (
  input  logic              clk,
  input  logic              rst_n,
  eth_tx_arbiter_if.slave   req,
  output logic              out_txen,
  output logic [7:0]        out_txd,
  output logic [1:0]        out_grant,
  output logic              out_busy,
  output logic              out_abort,
  output logic [15:0]       out_frame_count
);

  localparam int unsigned       CNT_W    = 16;
  localparam logic [CNT_W-1:0]  PRE_N    = CNT_W'(PREAMBLE_BYTES);
  localparam logic [CNT_W-1:0]  IFG_N    = CNT_W'(IFG_BYTES);
  localparam logic [CNT_W-1:0]  MAX_LAST = CNT_W'(MAX_FRAME - 1);
  localparam logic [7:0]        PRE_BYTE = 8'h55;
  localparam logic [7:0]        SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_DROP,
    S_IFG
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] ifg_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             last_grant_q;  // 1: requester 1 won the previous arbitration
  logic             tail_q;        // last byte is on the wire, close the frame next
  logic             ovf_q;         // oversize byte is on the wire, abort next
  logic             txen_q;
  logic [7:0]       txd_q;
  logic [1:0]       grant_q;
  logic             busy_q;
  logic             abort_q;
  logic [15:0]      frame_count_q;

  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             pick1;
  logic             accept_st;

  // Granted requester's stream.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    if (grant_q[1]) begin
      g_valid = req.in_req1_valid;
      g_last  = req.in_req1_last;
      g_data  = req.in_req1_data;
    end else if (grant_q[0]) begin
      g_valid = req.in_req0_valid;
      g_last  = req.in_req0_last;
      g_data  = req.in_req0_data;
    end
  end

  // Requester 1 wins alone, or on a tie when requester 0 won last time.
  assign pick1 = req.in_req1_valid && (!req.in_req0_valid || !last_grant_q);

  // Acceptance from the SFD cycle on; closed while the last byte is driven.
  assign accept_st = (state_q == S_SFD) || (state_q == S_DROP) ||
                     ((state_q == S_DATA) && !tail_q);

  assign req.out_req0_ready = accept_st && grant_q[0];
  assign req.out_req1_ready = accept_st && grant_q[1];

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pre_cnt_q     <= '0;
      ifg_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      last_grant_q  <= 1'b1;
      tail_q        <= 1'b0;
      ovf_q         <= 1'b0;
      txen_q        <= 1'b0;
      txd_q         <= 8'h00;
      grant_q       <= 2'b00;
      busy_q        <= 1'b0;
      abort_q       <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          txen_q <= 1'b0;
          txd_q  <= 8'h00;
          if (req.in_req0_valid || req.in_req1_valid) begin
            grant_q      <= pick1 ? 2'b10 : 2'b01;
            last_grant_q <= pick1;
            busy_q       <= 1'b1;
            txen_q       <= 1'b1;
            txd_q        <= PRE_BYTE;
            pre_cnt_q    <= CNT_W'(1);
            byte_cnt_q   <= '0;
            state_q      <= S_PREAMBLE;
          end
        end

        S_PREAMBLE: begin
          txen_q <= 1'b1;
          if (pre_cnt_q >= PRE_N) begin
            txd_q   <= SFD_BYTE;
            state_q <= S_SFD;
          end else begin
            txd_q     <= PRE_BYTE;
            pre_cnt_q <= pre_cnt_q + CNT_W'(1);
          end
        end

        S_SFD, S_DATA: begin
          if (tail_q) begin
            // Last byte has been driven; release the port.
            tail_q    <= 1'b0;
            txen_q    <= 1'b0;
            txd_q     <= 8'h00;
            grant_q   <= 2'b00;
            ifg_cnt_q <= CNT_W'(1);
            state_q   <= S_IFG;
          end else if (!g_valid) begin
            txen_q  <= 1'b0;
            txd_q   <= 8'h00;
            abort_q <= 1'b1;
            state_q <= S_DROP;
          end else begin
            txen_q     <= 1'b1;
            txd_q      <= g_data;
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            state_q    <= S_DATA;
            if (g_last) begin
              tail_q        <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end else if (byte_cnt_q == MAX_LAST) begin
              // Oversize byte still goes out; the abort follows it.
              ovf_q   <= 1'b1;
              state_q <= S_DROP;
            end
          end
        end

        S_DROP: begin
          txen_q  <= 1'b0;
          txd_q   <= 8'h00;
          abort_q <= ovf_q;
          ovf_q   <= 1'b0;
          if (g_valid && g_last) begin
            grant_q   <= 2'b00;
            ifg_cnt_q <= CNT_W'(1);
            state_q   <= S_IFG;
          end
        end

        S_IFG: begin
          txen_q <= 1'b0;
          txd_q  <= 8'h00;
          if (ifg_cnt_q >= IFG_N) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          txen_q  <= 1'b0;
          txd_q   <= 8'h00;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_txen        = txen_q;
  assign out_txd         = txd_q;
  assign out_grant       = grant_q;
  assign out_busy        = busy_q;
  assign out_abort       = abort_q;
  assign out_frame_count = frame_count_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: per-requester byte sources,
// expected transmit stream queued at load time and popped as bytes appear.
module tb_eth_tx_arbiter;

  localparam int unsigned PRE  = 7;
  localparam int unsigned IFG  = 12;
  localparam int unsigned MAXF = 100;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
  } src_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] g;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_txen;
  logic [7:0]  out_txd;
  logic [1:0]  out_grant;
  logic        out_busy;
  logic        out_abort;
  logic [15:0] out_frame_count;

  eth_tx_arbiter_if rq();

  eth_tx_arbiter #(
    .IFG_BYTES(IFG),
    .PREAMBLE_BYTES(PRE),
    .MAX_FRAME(MAXF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(rq.slave),
    .out_txen(out_txen),
    .out_txd(out_txd),
    .out_grant(out_grant),
    .out_busy(out_busy),
    .out_abort(out_abort),
    .out_frame_count(out_frame_count)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  src_t src0_q[$];
  src_t src1_q[$];
  exp_t exp_q[$];
  int   gap_q[$];
  int   gap0 = 0;
  int   gap1 = 0;
  int   hi_cnt = 0;
  int   abort_cnt = 0;
  int   low_run = 0;
  int   exp_count = 0;
  logic seen_hi = 1'b0;
  logic prev_txen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Per-cycle monitor: scoreboard pop on driven bytes plus invariants.
  task automatic check_outputs();
    exp_t e;
    if (out_txen) begin
      hi_cnt++;
      if (seen_hi && low_run > 0) gap_q.push_back(low_run);
      seen_hi = 1'b1;
      low_run = 0;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("txd", 32'(out_txd), 32'(e.d));
        chk("grant", 32'(out_grant), 32'(e.g));
      end
    end else begin
      low_run++;
      chk("txd_idle", 32'(out_txd), 32'd0);
    end
    if (out_abort) begin
      abort_cnt++;
      chk("abort_prev_txen", 32'(prev_txen), 32'd1);
      chk("abort_txen", 32'(out_txen), 32'd0);
    end
    chk("rdy0_grant", 32'(rq.out_req0_ready && (out_grant != 2'b01)), 32'd0);
    chk("rdy1_grant", 32'(rq.out_req1_ready && (out_grant != 2'b10)), 32'd0);
    prev_txen = out_txen;
  endtask

  task automatic drive();
    src_t s;
    if (gap0 > 0) begin
      rq.in_req0_valid = 1'b0;
      gap0--;
    end else if (src0_q.size() > 0) begin
      if (src0_q[0].gap > 0) begin
        s = src0_q.pop_front();
        gap0 = s.gap - 1;
        s.gap = 0;
        src0_q.push_front(s);
        rq.in_req0_valid = 1'b0;
      end else begin
        rq.in_req0_valid = 1'b1;
        rq.in_req0_data  = src0_q[0].d;
        rq.in_req0_last  = src0_q[0].l;
      end
    end else begin
      rq.in_req0_valid = 1'b0;
      rq.in_req0_data  = 8'h00;
      rq.in_req0_last  = 1'b0;
    end
    if (gap1 > 0) begin
      rq.in_req1_valid = 1'b0;
      gap1--;
    end else if (src1_q.size() > 0) begin
      if (src1_q[0].gap > 0) begin
        s = src1_q.pop_front();
        gap1 = s.gap - 1;
        s.gap = 0;
        src1_q.push_front(s);
        rq.in_req1_valid = 1'b0;
      end else begin
        rq.in_req1_valid = 1'b1;
        rq.in_req1_data  = src1_q[0].d;
        rq.in_req1_last  = src1_q[0].l;
      end
    end else begin
      rq.in_req1_valid = 1'b0;
      rq.in_req1_data  = 8'h00;
      rq.in_req1_last  = 1'b0;
    end
  endtask

  task automatic tick();
    logic a0;
    logic a1;
    a0 = rq.in_req0_valid && rq.out_req0_ready;
    a1 = rq.in_req1_valid && rq.out_req1_ready;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (a0 && src0_q.size() > 0) src0_q.delete(0);
    if (a1 && src1_q.size() > 0) src1_q.delete(0);
    drive();
  endtask

  // Queue a frame at a requester; expect preamble, SFD and the first n_out bytes.
  task automatic load(input int who, input int len, input int gap_at, input int gap_len,
                      input int n_out, input bit seq);
    src_t s;
    exp_t e;
    e.g = (who == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < int'(PRE); i++) begin
      e.d = 8'h55;
      exp_q.push_back(e);
    end
    e.d = 8'hD5;
    exp_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      s.d   = seq ? 8'(i) : 8'($urandom_range(0, 255));
      s.l   = (i == len - 1);
      s.gap = (i == gap_at) ? gap_len : 0;
      if (who == 0) src0_q.push_back(s);
      else src1_q.push_back(s);
      if (i < n_out) begin
        e.d = s.d;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0 &&
             gap0 == 0 && gap1 == 0 && !out_busy) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txen"},  32'(out_txen), 32'd0);
    chk({tag, "_txd"},   32'(out_txd), 32'd0);
    chk({tag, "_grant"}, 32'(out_grant), 32'd0);
    chk({tag, "_busy"},  32'(out_busy), 32'd0);
    chk({tag, "_abort"}, 32'(out_abort), 32'd0);
    chk({tag, "_count"}, 32'(out_frame_count), 32'd0);
    chk({tag, "_rdy0"},  32'(rq.out_req0_ready), 32'd0);
    chk({tag, "_rdy1"},  32'(rq.out_req1_ready), 32'd0);
  endtask

  initial begin
    int n;
    int ab0;
    rst_n = 1'b0;
    drive();
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Single 64-byte frame from req0, bytes 0x00..0x3F.
    hi_cnt = 0;
    load(0, 64, -1, 0, 64, 1'b1);
    exp_count = 1;
    tick();
    tick();
    chk("t1_grant", 32'(out_grant), 32'h1);
    chk("t1_busy", 32'(out_busy), 32'd1);
    chk("t1_txen", 32'(out_txen), 32'd1);
    repeat (PRE - 1) tick();
    chk("t1_rdy_pre", 32'(rq.out_req0_ready), 32'd0);
    tick();
    chk("t1_rdy_sfd", 32'(rq.out_req0_ready), 32'd1);
    chk("t1_sfd", 32'(out_txd), 32'hD5);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("t1_frame_end", 32'(exp_q.size()), 32'd0);
    chk("t1_txen_cycles", 32'(hi_cnt), 32'd72);
    for (int i = 0; i < int'(IFG); i++) begin
      tick();
      chk("t1_ifg_txen", 32'(out_txen), 32'd0);
      chk("t1_ifg_busy", 32'(out_busy), 32'd1);
    end
    tick();
    chk("t1_post_busy", 32'(out_busy), 32'd0);
    chk("t1_post_grant", 32'(out_grant), 32'd0);
    chk("t1_count", 32'(out_frame_count), 32'(exp_count));
    wait_done("t1_done", 50);

    // Reset, then both requesters continuously with 60-byte frames.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    chk("t2_count_rst", 32'(out_frame_count), 32'd0);
    seen_hi = 1'b0;
    gap_q.delete();
    ab0 = abort_cnt;
    load(0, 60, -1, 0, 60, 1'b0);
    load(1, 60, -1, 0, 60, 1'b0);
    load(0, 60, -1, 0, 60, 1'b0);
    load(1, 60, -1, 0, 60, 1'b0);
    exp_count += 4;
    wait_done("t2_done", 800);
    chk("t2_gap_n", 32'(gap_q.size()), 32'd3);
    for (int i = 0; i < gap_q.size(); i++) chk("t2_gap_len", 32'(gap_q[i]), 32'(IFG + 1));
    chk("t2_count", 32'(out_frame_count), 32'(exp_count));
    chk("t2_aborts", 32'(abort_cnt - ab0), 32'd0);

    // req1 underruns after 20 data bytes for 3 cycles, then completes.
    ab0 = abort_cnt;
    load(1, 40, 20, 3, 20, 1'b0);
    wait_done("t3_done", 400);
    chk("t3_aborts", 32'(abort_cnt - ab0), 32'd1);
    chk("t3_count", 32'(out_frame_count), 32'(exp_count));

    // 150-byte frame against MAX_FRAME=100.
    ab0 = abort_cnt;
    load(0, 150, -1, 0, MAXF, 1'b0);
    wait_done("t4_done", 600);
    chk("t4_aborts", 32'(abort_cnt - ab0), 32'd1);
    chk("t4_count", 32'(out_frame_count), 32'(exp_count));

    // Reset during data byte 30, then both pending: req0 restarts first.
    load(0, 60, -1, 0, 60, 1'b0);
    n = 0;
    while (exp_q.size() > 29 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_at_byte30", 32'(exp_q.size()), 32'd29);
    rst_n = 1'b0;
    exp_q.delete();
    src0_q.delete();
    src1_q.delete();
    gap0 = 0;
    gap1 = 0;
    rq.in_req0_valid = 1'b0;
    rq.in_req1_valid = 1'b0;
    tick();
    chk_reset_vals("t5_rst");
    rst_n = 1'b1;
    exp_count = 0;
    load(0, 20, -1, 0, 20, 1'b0);
    load(1, 20, -1, 0, 20, 1'b0);
    exp_count += 2;
    wait_done("t5_done", 400);
    chk("t5_count", 32'(out_frame_count), 32'(exp_count));

    // Frame counter wrap from 0xFFFF.
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    chk("t6_preload", 32'(out_frame_count), 32'hFFFF);
    load(0, 10, -1, 0, 10, 1'b0);
    wait_done("t6_done", 200);
    chk("t6_wrap", 32'(out_frame_count), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
